adc_link_bringup_ctrl: RTL
==========================

Name: adc_link_bringup_ctrl

Overview:
- Sequences bring-up of the AD9081 JESD204C RX/TX link: drives the device reset (rstb), the HMC clock-chip sync (hmc_sync) and the rxen/txen enables.
- Waits for SYSREF edges, then waits for a stable link-up indication.
- Retries on timeout or link loss.
- Sits beside the JESD system wrapper in the AXI-Lite clock domain. Replaces software GPIO bit-banging of those pins with a hardware state machine started and monitored from a register.

Parameters:
- RST_CYCLES, 1000: cycles rstb is held low in RESET.
- SETTLE_CYCLES, 10000: cycles after rstb release before sync.
- SYNC_CYCLES, 16: width of the hmc_sync pulse in cycles.
- SYSREF_COUNT, 4: SYSREF rising edges required before enabling the link.
- LINK_STABLE, 8: consecutive cycles link_up must be high to qualify.
- LINK_TIMEOUT, 1000000: maximum cycles allowed in SYSREF_WAIT plus LINK_WAIT per attempt.
- MAX_RETRIES, 3: automatic retries before FAULT (0 = no retry).
- TX_ENABLE, 1: when 1, txen follows rxen; when 0, txen stays 0.

Ports:
- axil_aclk  in  1  sole clock.
- axil_areset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or FAULT.
- abort  in  1  return to IDLE; highest priority.
- sysref_in  in  1  SYSREF, already synchronised to axil_aclk upstream.
- link_up  in  1  JESD RX link status, synchronous to axil_aclk.
- rstb  out  1  device reset, active low.
- hmc_sync  out  1  clock-chip sync pulse.
- rxen  out  2  RX enables.
- txen  out  2  TX enables.
- busy  out  1  sequence in progress.
- ready  out  1  link running.
- error  out  1  sticky failure flag.
- state  out  3  current state code.
- retry_cnt  out  4  retries used in the current run.
- drop_cnt  out  16  link drops seen in RUNNING; saturating.

Behaviour:
- Reset (axil_areset_n=0 at a clock edge): state=IDLE, rstb=0, hmc_sync=0, rxen=0, txen=0, busy=0, ready=0, error=0, retry_cnt=0, drop_cnt=0, all internal counters 0.
- State codes: IDLE=0, RESET=1, SETTLE=2, SYNC=3, SYSREF_WAIT=4, LINK_WAIT=5, RUNNING=6, FAULT=7.
- All outputs are registered and decoded from the state entered; the change is visible the cycle after the transition edge.
- IDLE: rstb=0, enables=0. On start -> RESET; clear error and retry_cnt. drop_cnt is cleared only by reset.
- RESET: rstb=0 for exactly RST_CYCLES cycles -> SETTLE.
- SETTLE: rstb=1 for SETTLE_CYCLES cycles -> SYNC.
- SYNC: hmc_sync=1 for exactly SYNC_CYCLES cycles -> SYSREF_WAIT. hmc_sync=0 in every other state.
- SYSREF_WAIT:
  - Rising-edge detect on sysref_in (registered previous value, cleared on entry).
  - On the SYSREF_COUNT-th edge -> LINK_WAIT.
  - The attempt timeout counter starts at SYSREF_WAIT entry.
- LINK_WAIT:
  - rxen=2'b11; txen=2'b11 if TX_ENABLE, else 0.
  - Stability counter increments while link_up=1 and resets to 0 when link_up=0.
  - When it reaches LINK_STABLE -> RUNNING.
- Timeout: attempt counter reaches LINK_TIMEOUT in SYSREF_WAIT or LINK_WAIT -> RETRY decision.
- RUNNING:
  - ready=1, enables held.
  - link_up=0 for a single cycle -> drop_cnt++ (saturates at 0xFFFF), then RETRY decision.
- RETRY decision (combinational, same edge):
  - If retry_cnt < MAX_RETRIES: retry_cnt++, go to RESET. Enables drop to 0 and rstb to 0 in the next cycle.
  - Otherwise go to FAULT.
- FAULT: error=1, rstb=0, enables=0. start -> RESET (clears error, retry_cnt).
- busy=1 in states 1..5; ready=1 only in RUNNING.
- Priority at any edge: reset > abort > timeout/link-drop > normal progression.
- abort in any state -> IDLE next cycle with all outputs deasserted. error and retry_cnt are held, not cleared.
- start outside IDLE/FAULT is ignored. start and abort together -> abort wins.
- A timeout and the qualifying event on the same edge: the qualifying event wins (the SYSREF_COUNT-th edge, or the LINK_STABLE-th cycle of link_up).
- Counters are sized with $clog2(param+1). Every counter restarts at 0 on each state entry. Parameters of 0 for RST/SETTLE/SYNC are illegal.

Test Plan:
(Parameters for all: RST=4, SETTLE=6, SYNC=3, SYSREF_COUNT=2, LINK_STABLE=8, LINK_TIMEOUT=50, MAX_RETRIES=2.)
- Happy path: start at t0; sysref pulses every 5 cycles; link_up rises 3 cycles after rxen.
  - rstb low 4 cycles, then high.
  - hmc_sync high exactly 3 cycles.
  - rxen=txen=2'b11 after the 2nd sysref edge.
  - ready=1 exactly 8 cycles after link_up rises; state=6; retry_cnt=0.
- Link flicker: in LINK_WAIT, link_up high 7 cycles, low 1 cycle, then high -> ready asserts only after 8 further consecutive cycles.
- Timeout exhaustion: no sysref.
  - Two retries: retry_cnt goes 1, then 2, each re-entering RESET with rstb=0.
  - Third timeout -> state=7, error=1, rxen=txen=0.
  - A subsequent start clears error and retry_cnt=0.
- Link drop in RUNNING: link_up low for 1 cycle -> drop_cnt=1, ready=0 next cycle, state=1, retry_cnt=1. The sequence recompletes to RUNNING.
- Abort mid-SYNC: abort asserted together with start -> next cycle state=0, hmc_sync=0, rstb=0, busy=0. A start raised in the same cycle is ignored.
- Reset mid-LINK_WAIT: axil_areset_n=0 for 1 edge -> all outputs at reset values, drop_cnt=0, state=0.

Source files
------------

// File: rtl/adc_link_bringup_ctrl_if.sv
// Control and status bundle for the AD9081 JESD204C link bring-up controller.
// The slave side is the controller; the master side is whoever drives
// start/abort and supplies the SYSREF and link status.
interface adc_link_bringup_ctrl_if;
    logic        start;
    logic        abort;
    logic        sysref_in;
    logic        link_up;
    logic        rstb;
    logic        hmc_sync;
    logic [1:0]  rxen;
    logic [1:0]  txen;
    logic        busy;
    logic        ready;
    logic        error;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] drop_cnt;

    modport master (
        output start, abort, sysref_in, link_up,
        input  rstb, hmc_sync, rxen, txen, busy, ready, error, state, retry_cnt, drop_cnt
    );

    modport slave (
        input  start, abort, sysref_in, link_up,
        output rstb, hmc_sync, rxen, txen, busy, ready, error, state, retry_cnt, drop_cnt
    );
endinterface

// File: rtl/adc_link_bringup_ctrl.sv
// AD9081 JESD204C link bring-up sequencer: device reset, settle, HMC sync
// pulse, SYSREF qualification and link-up qualification. A failed attempt
// (timeout or link loss) is retried up to MAX_RETRIES times before FAULT.
module adc_link_bringup_ctrl #(
    parameter int RST_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 10000,
    parameter int SYNC_CYCLES   = 16,
    parameter int SYSREF_COUNT  = 4,
    parameter int LINK_STABLE   = 8,
    parameter int LINK_TIMEOUT  = 1000000,
    parameter int MAX_RETRIES   = 3,
    parameter int TX_ENABLE     = 1
) (
    input  logic                   axil_aclk,
    input  logic                   axil_areset_n,
    adc_link_bringup_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RESET       = 3'd1,
        S_SETTLE      = 3'd2,
        S_SYNC        = 3'd3,
        S_SYSREF_WAIT = 3'd4,
        S_LINK_WAIT   = 3'd5,
        S_RUNNING     = 3'd6,
        S_FAULT       = 3'd7
    } state_e;

    // One phase counter is shared by RESET/SETTLE/SYNC; it must hold the longest.
    localparam int PMAX = (RST_CYCLES > SETTLE_CYCLES) ?
                          ((RST_CYCLES > SYNC_CYCLES) ? RST_CYCLES : SYNC_CYCLES) :
                          ((SETTLE_CYCLES > SYNC_CYCLES) ? SETTLE_CYCLES : SYNC_CYCLES);
    localparam int PW = $clog2(PMAX + 1);
    localparam int TW = (LINK_TIMEOUT > 0) ? $clog2(LINK_TIMEOUT + 1) : 1;
    localparam int EW = (SYSREF_COUNT > 0) ? $clog2(SYSREF_COUNT + 1) : 1;
    localparam int SW = (LINK_STABLE > 0)  ? $clog2(LINK_STABLE + 1)  : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   att_q, att_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic [SW-1:0]   stab_q, stab_d;
    logic            sref_prev_q, sref_prev_d;
    logic [3:0]      retry_q, retry_d;
    logic [15:0]     drop_q, drop_d;
    logic            err_q, err_d;
    logic            rstb_q, rstb_d;
    logic            hmc_q, hmc_d;
    logic [1:0]      rxen_q, rxen_d;
    logic [1:0]      txen_q, txen_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            retry_go;
    logic            sref_rise;
    logic            timeout;

    // Next-state, counters and the registered output decode of the state being entered.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        att_d       = att_q;
        edge_d      = edge_q;
        stab_d      = stab_q;
        sref_prev_d = sref_prev_q;
        retry_d     = retry_q;
        drop_d      = drop_q;
        err_d       = err_q;
        retry_go    = 1'b0;
        sref_rise   = bus.sysref_in & ~sref_prev_q;
        timeout     = (att_q == TW'(LINK_TIMEOUT - 1));

        case (state_q)
            S_IDLE, S_FAULT: begin
                if (bus.start) begin
                    state_d = S_RESET;
                    err_d   = 1'b0;
                    retry_d = '0;
                end
            end
            S_RESET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PW'(RST_CYCLES - 1)) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PW'(SETTLE_CYCLES - 1)) state_d = S_SYNC;
            end
            S_SYNC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PW'(SYNC_CYCLES - 1)) state_d = S_SYSREF_WAIT;
            end
            S_SYSREF_WAIT: begin
                att_d       = att_q + 1'b1;
                sref_prev_d = bus.sysref_in;
                if (sref_rise) edge_d = edge_q + 1'b1;
                // the qualifying edge beats a coincident timeout
                if (sref_rise && edge_q == EW'(SYSREF_COUNT - 1)) state_d = S_LINK_WAIT;
                else if (timeout)                                  retry_go = 1'b1;
            end
            S_LINK_WAIT: begin
                att_d  = att_q + 1'b1;
                stab_d = bus.link_up ? stab_q + 1'b1 : '0;
                if (bus.link_up && stab_q == SW'(LINK_STABLE - 1)) state_d = S_RUNNING;
                else if (timeout)                                   retry_go = 1'b1;
            end
            S_RUNNING: begin
                if (!bus.link_up) begin
                    if (drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
                    retry_go = 1'b1;
                end
            end
            default: ;
        endcase

        if (retry_go) begin
            if (retry_q < 4'(MAX_RETRIES)) begin
                retry_d = retry_q + 1'b1;
                state_d = S_RESET;
            end else begin
                state_d = S_FAULT;
            end
        end

        if (state_d == S_FAULT) err_d = 1'b1;

        // abort overrides everything but leaves the status history intact
        if (bus.abort) begin
            state_d = S_IDLE;
            retry_d = retry_q;
            err_d   = err_q;
            drop_d  = drop_q;
        end

        // every state starts with fresh counters; the attempt timer spans SYSREF_WAIT+LINK_WAIT
        if (state_d != state_q) begin
            cnt_d       = '0;
            edge_d      = '0;
            stab_d      = '0;
            sref_prev_d = 1'b0;
            if (state_d == S_SYSREF_WAIT) att_d = '0;
        end

        rstb_d  = (state_d == S_SETTLE) || (state_d == S_SYNC) || (state_d == S_SYSREF_WAIT) ||
                  (state_d == S_LINK_WAIT) || (state_d == S_RUNNING);
        hmc_d   = (state_d == S_SYNC);
        rxen_d  = ((state_d == S_LINK_WAIT) || (state_d == S_RUNNING)) ? 2'b11 : 2'b00;
        txen_d  = (TX_ENABLE != 0) ? rxen_d : 2'b00;
        busy_d  = (state_d == S_RESET) || (state_d == S_SETTLE) || (state_d == S_SYNC) ||
                  (state_d == S_SYSREF_WAIT) || (state_d == S_LINK_WAIT);
        ready_d = (state_d == S_RUNNING);
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge axil_aclk) begin
        if (!axil_areset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            att_q       <= '0;
            edge_q      <= '0;
            stab_q      <= '0;
            sref_prev_q <= 1'b0;
            retry_q     <= '0;
            drop_q      <= '0;
            err_q       <= 1'b0;
            rstb_q      <= 1'b0;
            hmc_q       <= 1'b0;
            rxen_q      <= 2'b00;
            txen_q      <= 2'b00;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            att_q       <= att_d;
            edge_q      <= edge_d;
            stab_q      <= stab_d;
            sref_prev_q <= sref_prev_d;
            retry_q     <= retry_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            rstb_q      <= rstb_d;
            hmc_q       <= hmc_d;
            rxen_q      <= rxen_d;
            txen_q      <= txen_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.rstb      = rstb_q;
    assign bus.hmc_sync  = hmc_q;
    assign bus.rxen      = rxen_q;
    assign bus.txen      = txen_q;
    assign bus.busy      = busy_q;
    assign bus.ready     = ready_q;
    assign bus.error     = err_q;
    assign bus.state     = state_q;
    assign bus.retry_cnt = retry_q;
    assign bus.drop_cnt  = drop_q;

endmodule
